// File: rtl/hash_scorer.sv
// rtl/hash_scorer.sv - serial Hamming-distance scorer that keeps the best hash/nonce pair
module hash_scorer #(
  parameter int HASH_WIDTH  = 1024,
  parameter int CHUNK_WIDTH = 64,
  parameter int NONCE_WIDTH = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   hash_valid_i,
  input  logic [HASH_WIDTH-1:0]  hash_i,
  input  logic [NONCE_WIDTH-1:0] nonce_i,
  input  logic [HASH_WIDTH-1:0]  target_i,
  input  logic                   clear_best_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   new_best_o,
  output logic [10:0]            last_distance_o,
  output logic [10:0]            best_distance_o,
  output logic [NONCE_WIDTH-1:0] best_nonce_o,
  output logic [31:0]            hashes_scored_o
);

  localparam int N_CHUNKS = HASH_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);
  localparam logic [10:0] NO_RESULT = 11'd2047;

  typedef enum logic [1:0] {S_IDLE, S_SCORE, S_COMPARE} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [HASH_WIDTH-1:0]  r_diff;
  logic [NONCE_WIDTH-1:0] r_nonce;
  logic [10:0]            r_acc;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_done;
  logic                   r_new_best;
  logic [10:0]            r_last;
  logic [10:0]            r_best;
  logic [NONCE_WIDTH-1:0] r_best_nonce;
  logic [31:0]            r_count;
  logic [CHUNK_WIDTH-1:0] w_chunk;
  logic [10:0]            w_pop;

  assign w_chunk = r_diff[r_idx*CHUNK_WIDTH +: CHUNK_WIDTH];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      w_pop = w_pop + {10'd0, w_chunk[i]};
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (hash_valid_i) w_next_state = S_SCORE;
      S_SCORE:   if (r_idx == LAST_IDX) w_next_state = S_COMPARE;
      S_COMPARE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_diff       <= '0;
      r_nonce      <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_done       <= 1'b0;
      r_new_best   <= 1'b0;
      r_last       <= '0;
      r_best       <= NO_RESULT;
      r_best_nonce <= '0;
      r_count      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_done     <= 1'b0;
      r_new_best <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hash_valid_i) begin
            r_diff  <= hash_i ^ target_i;
            r_nonce <= nonce_i;
            r_acc   <= '0;
            r_idx   <= '0;
          end
        end
        S_SCORE: begin
          r_acc <= r_acc + w_pop;
          r_idx <= r_idx + IDX_W'(1);
        end
        S_COMPARE: begin
          r_last  <= r_acc;
          r_count <= r_count + 32'd1;
          r_done  <= 1'b1;
          // A simultaneous clear takes priority over a new best
          if (!clear_best_i && (r_acc < r_best)) begin
            r_best       <= r_acc;
            r_best_nonce <= r_nonce;
            r_new_best   <= 1'b1;
          end
        end
        default: ;
      endcase
      if (clear_best_i) begin
        r_best       <= NO_RESULT;
        r_best_nonce <= '0;
      end
    end
  end

  always_comb begin
    ready_o = (r_state == S_IDLE);
  end

  assign done_o          = r_done;
  assign new_best_o      = r_new_best;
  assign last_distance_o = r_last;
  assign best_distance_o = r_best;
  assign best_nonce_o    = r_best_nonce;
  assign hashes_scored_o = r_count;

endmodule

// File: tb/tb_hash_scorer.sv
// tb/tb_hash_scorer.sv - directed table-driven bench for hash_scorer
module tb_hash_scorer;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          hash_valid_i = 1'b0;
  logic [1023:0] hash_i = '0;
  logic [255:0]  nonce_i = '0;
  logic [1023:0] target_i = '0;
  logic          clear_best_i = 1'b0;
  logic          ready_o, done_o, new_best_o;
  logic [10:0]   last_distance_o, best_distance_o;
  logic [255:0]  best_nonce_o;
  logic [31:0]   hashes_scored_o;

  int n_pass = 0;
  int n_total = 0;

  hash_scorer dut (
    .clk_i(clk_i), .rst_i(rst_i), .hash_valid_i(hash_valid_i), .hash_i(hash_i),
    .nonce_i(nonce_i), .target_i(target_i), .clear_best_i(clear_best_i),
    .ready_o(ready_o), .done_o(done_o), .new_best_o(new_best_o),
    .last_distance_o(last_distance_o), .best_distance_o(best_distance_o),
    .best_nonce_o(best_nonce_o), .hashes_scored_o(hashes_scored_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int           k;
    bit           hi;
    logic [255:0] nonce;
    bit           pre_clear;
    bit           clr_cmp;
    int           e_last;
    int           e_best;
    logic [255:0] e_bn;
    bit           e_nb;
    int           e_cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [1023:0] mk(input int k, input bit hi);
    logic [1023:0] m;
    m = '0;
    for (int i = 0; i < k; i++) begin
      if (hi) m[1023-i] = 1'b1;
      else    m[i] = 1'b1;
    end
    return m;
  endfunction

  // Issue one hash at distance k from tgt and check the full completion handshake.
  task automatic do_score(input int k, input bit hi, input logic [1023:0] tgt,
                          input logic [255:0] nonce, input bit clr_cmp,
                          input int e_last, input int e_best, input logic [255:0] e_bn,
                          input bit e_nb, input int e_cnt, input string tag);
    int lat;
    @(negedge clk_i);
    chk({tag, " ready_before"}, 256'(ready_o), 256'(1));
    hash_valid_i = 1'b1;
    target_i     = tgt;
    hash_i       = tgt ^ mk(k, hi);
    nonce_i      = nonce;
    @(posedge clk_i);
    #1;
    hash_valid_i = 1'b0;
    hash_i       = ~hash_i;
    target_i     = {32{$urandom}};
    nonce_i      = '1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk_i);
      lat++;
      #1;
      if (clr_cmp && lat == 17) clear_best_i = 1'b0;
      if (lat == 8) chk({tag, " ready_busy"}, 256'(ready_o), 256'(0));
      if (done_o) break;
      if (clr_cmp && lat == 16) clear_best_i = 1'b1;
    end
    clear_best_i = 1'b0;
    chk({tag, " latency"}, 256'(lat), 256'(17));
    chk({tag, " done"}, 256'(done_o), 256'(1));
    chk({tag, " ready_at_done"}, 256'(ready_o), 256'(1));
    chk({tag, " new_best"}, 256'(new_best_o), 256'(e_nb));
    chk({tag, " last_distance"}, 256'(last_distance_o), 256'(e_last));
    chk({tag, " best_distance"}, 256'(best_distance_o), 256'(e_best));
    chk({tag, " best_nonce"}, best_nonce_o, e_bn);
    chk({tag, " hashes_scored"}, 256'(hashes_scored_o), 256'(e_cnt));
    @(posedge clk_i);
    #1;
    chk({tag, " done_one_cycle"}, 256'(done_o), 256'(0));
    chk({tag, " new_best_one_cycle"}, 256'(new_best_o), 256'(0));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " rst ready"}, 256'(ready_o), 256'(1));
    chk({tag, " rst done"}, 256'(done_o), 256'(0));
    chk({tag, " rst new_best"}, 256'(new_best_o), 256'(0));
    chk({tag, " rst last"}, 256'(last_distance_o), 256'(0));
    chk({tag, " rst best"}, 256'(best_distance_o), 256'(2047));
    chk({tag, " rst best_nonce"}, best_nonce_o, 256'(0));
    chk({tag, " rst count"}, 256'(hashes_scored_o), 256'(0));
  endtask

  logic [1023:0] tgt_a;
  logic [1023:0] tgt_b;

  initial begin
    tgt_a = {128{8'h5A}};
    tgt_b = {32{32'hDEADBEEF}};
    //          k     hi  nonce      pre clr  last  best  bn         nb cnt
    vecs[0] = '{0,    0, 256'h1,    0, 0,    0,    0,    256'h1,    1, 1};
    vecs[1] = '{1024, 0, 256'h2,    1, 0,    1024, 1024, 256'h2,    1, 2};
    vecs[2] = '{400,  0, 256'hA,    1, 0,    400,  400,  256'hA,    1, 3};
    vecs[3] = '{400,  1, 256'hB,    0, 0,    400,  400,  256'hA,    0, 4};
    vecs[4] = '{390,  1, 256'hC,    0, 0,    390,  390,  256'hC,    1, 5};
    vecs[5] = '{10,   1, 256'hD,    0, 1,    10,   2047, 256'h0,    0, 6};
    vecs[6] = '{1023, 0, 256'hE,    0, 0,    1023, 1023, 256'hE,    1, 7};
    vecs[7] = '{1,    0, 256'hF,    0, 0,    1,    1,    256'hF,    1, 8};
    vecs[8] = '{5,    1, 256'h10,   0, 0,    5,    1,    256'hF,    0, 9};
    vecs[9] = '{0,    1, {4{64'hC0FFEE}}, 0, 0, 0, 0,   {4{64'hC0FFEE}}, 1, 10};

    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_state("initial");
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre_clear) begin
        @(negedge clk_i);
        clear_best_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_best_i = 1'b0;
        chk($sformatf("v%0d pre_clear best", i), 256'(best_distance_o), 256'(2047));
      end
      do_score(vecs[i].k, vecs[i].hi, (i % 2 == 0) ? tgt_a : tgt_b, vecs[i].nonce,
               vecs[i].clr_cmp, vecs[i].e_last, vecs[i].e_best, vecs[i].e_bn,
               vecs[i].e_nb, vecs[i].e_cnt, $sformatf("v%0d", i));
    end

    // Reset in the middle of scoring: idx=7 after seven score edges
    @(negedge clk_i);
    hash_valid_i = 1'b1;
    target_i     = tgt_a;
    hash_i       = tgt_a ^ mk(50, 0);
    nonce_i      = 256'h77;
    @(posedge clk_i);
    #1;
    hash_valid_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_state("midscore");
    @(negedge clk_i);
    rst_i = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 25; c++) begin
        @(posedge clk_i);
        #1;
        if (done_o) seen++;
      end
      chk("midscore no_done", 256'(seen), 256'(0));
    end
    do_score(33, 1, tgt_b, 256'h99, 0, 33, 33, 256'h99, 1, 1, "after_rst");

    // Continuous hash_valid_i with data changing every cycle
    @(negedge clk_i);
    clear_best_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_best_i = 1'b0;
    begin
      int dones;
      bit exp_done;
      dones = 0;
      hash_valid_i = 1'b1;
      target_i = tgt_b;
      for (int c = 0; c < 56; c++) begin
        @(negedge clk_i);
        hash_i  = tgt_b ^ mk(3 * c + 7, c[0]);
        nonce_i = 256'(c + 1000);
        @(posedge clk_i);
        #1;
        exp_done = (c == 17) || (c == 35) || (c == 53);
        chk($sformatf("stream done c%0d", c), 256'(done_o), 256'(exp_done));
        if (done_o && exp_done) begin
          dones++;
          chk($sformatf("stream last c%0d", c), 256'(last_distance_o), 256'(3 * (c - 17) + 7));
        end
      end
      hash_valid_i = 1'b0;
      chk("stream done_count", 256'(dones), 256'(3));
      chk("stream best", 256'(best_distance_o), 256'(7));
      chk("stream best_nonce", best_nonce_o, 256'(1000));
      chk("stream count", 256'(hashes_scored_o), 256'(4));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
